// File: rtl/phase_to_amplitude.sv
// ============================================================================
// Module      : phase_to_amplitude
// Description : NCO phase-to-amplitude converter. A quarter-wave sine table
//               with quadrant mirroring/negation feeds a 3-stage valid/ready
//               pipeline that produces signed sine and cosine samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_to_amplitude #(
  parameter int WIDTH    = 26,
  parameter int DECIMALS = 16,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        phase_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic signed [OUT_W-1:0] sin_out_o,
  output logic signed [OUT_W-1:0] cos_out_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  localparam int  C_INT_W  = WIDTH - DECIMALS;
  localparam int  C_ADDR_W = C_INT_W - 2;
  localparam int  C_DEPTH  = 1 << C_ADDR_W;
  localparam real C_PI     = 3.14159265358979323846;
  localparam real C_AMP    = real'((1 << (OUT_W - 1)) - 1);

  // Table sampled at (k + 0.5) so that ~addr is an exact mirror and no entry is zero.
  function automatic logic [OUT_W-2:0] rom_entry(input int k);
    real x;
    x = C_AMP * $sin(2.0 * C_PI * (real'(k) + 0.5) / real'(1 << C_INT_W));
    return (OUT_W-1)'($rtoi(x + 0.5));
  endfunction

  logic [OUT_W-2:0] rom [C_DEPTH];

  for (genvar k = 0; k < C_DEPTH; k++) begin : g_rom
    assign rom[k] = rom_entry(k);
  end

  if (DECIMALS > 0) begin : g_frac
    logic unused_frac;
    assign unused_frac = ^phase_i[DECIMALS-1:0];
  end

  logic                advance;
  logic                s1_valid_q;
  logic [1:0]          s1_quad_q;
  logic [C_ADDR_W-1:0] s1_addr_q;
  logic [1:0]          cos_quad;
  logic [C_ADDR_W-1:0] sin_addr;
  logic [C_ADDR_W-1:0] cos_addr;
  logic                s2_valid_q;
  logic [OUT_W-2:0]    s2_sin_q;
  logic [OUT_W-2:0]    s2_cos_q;
  logic                s2_sin_neg_q;
  logic                s2_cos_neg_q;
  logic signed [OUT_W-1:0] sin_mag;
  logic signed [OUT_W-1:0] cos_mag;
  logic signed [OUT_W-1:0] sin_d;
  logic signed [OUT_W-1:0] cos_d;
  logic signed [OUT_W-1:0] sin_q;
  logic signed [OUT_W-1:0] cos_q;
  logic                out_valid_q;

  assign advance    = !out_valid_q || out_ready_i;
  assign in_ready_o = advance;

  // Cosine leads sine by one quadrant; odd quadrants read the table backwards.
  assign cos_quad = s1_quad_q + 2'd1;
  assign sin_addr = s1_quad_q[0] ? ~s1_addr_q : s1_addr_q;
  assign cos_addr = cos_quad[0]  ? ~s1_addr_q : s1_addr_q;

  assign sin_mag = {1'b0, s2_sin_q};
  assign cos_mag = {1'b0, s2_cos_q};
  assign sin_d   = s2_sin_neg_q ? -sin_mag : sin_mag;
  assign cos_d   = s2_cos_neg_q ? -cos_mag : cos_mag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid_i;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid_i) begin
      s1_quad_q <= phase_i[WIDTH-1 -: 2];
      s1_addr_q <= phase_i[DECIMALS +: C_ADDR_W];
    end
    if (advance && s1_valid_q) begin
      s2_sin_q     <= rom[sin_addr];
      s2_cos_q     <= rom[cos_addr];
      s2_sin_neg_q <= s1_quad_q[1];
      s2_cos_neg_q <= cos_quad[1];
    end
  end

  assign sin_out_o   = sin_q;
  assign cos_out_o   = cos_q;
  assign out_valid_o = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_to_amplitude.sv
// ============================================================================
// Module      : tb_phase_to_amplitude
// Description : Directed self-checking bench for phase_to_amplitude.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_to_amplitude;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [25:0]        phase;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] sin_o;
  logic signed [15:0] cos_o;
  logic               out_valid;
  logic               out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int rom_m [256];

  always #5 clk = ~clk;

  phase_to_amplitude dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .phase_i    (phase),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .sin_out_o  (sin_o),
    .cos_out_o  (cos_o),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int p, input bit is_cos);
    int q, a, addr, v;
    q = (p >> 8) & 3;
    if (is_cos) q = (q + 1) & 3;
    a    = p & 255;
    addr = q[0] ? 255 - a : a;
    v    = rom_m[addr];
    return q[1] ? -v : v;
  endfunction

  task automatic single(input string tag, input logic [25:0] ph,
                        input int exp_s, input int exp_c);
    phase    = ph;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sin"}, sin_o, exp_s);
    check({tag, "_cos"}, cos_o, exp_c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, got, n_out, norm_bad, acc, xfer;
    int p5 [5];
    longint ss, lim_lo, lim_hi;
    logic signed [15:0] cap_s, cap_c;

    for (int k = 0; k < 256; k++)
      rom_m[k] = $rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * (real'(k) + 0.5) / 1024.0) + 0.5);

    // Reset state
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    phase     = '0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_sin", sin_o, 0);
    check("rst_cos", cos_o, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    tick();

    // Quadrant corners, fraction, wrap
    single("ph0", 26'h0000000, 101, 32767);
    tick();
    check("hold_valid", out_valid, 0);
    check("hold_sin", sin_o, 101);
    single("ph256", 26'h1000000, 32767, -101);
    single("ph512", 26'h2000000, -101, -32767);
    single("frac", 26'h000FFFF, 101, 32767);
    single("allones", 26'h3FFFFFF, -101, 32767);
    tick();

    // Full-circle stream
    n_out    = 0;
    norm_bad = 0;
    lim_lo   = 64'd1073676289 - 64'd10736763;
    lim_hi   = 64'd1073676289 + 64'd10736763;
    for (int t = 1; t <= 1030; t++) begin
      if (t <= 1024) begin
        phase    = 26'((t - 1) << 16);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("s4_valid", out_valid, (t >= 3 && t <= 1026) ? 1 : 0);
      if (out_valid) begin
        check("s4_sin", sin_o, model(t - 3, 1'b0));
        check("s4_cos", cos_o, model(t - 3, 1'b1));
        ss = longint'(sin_o) * longint'(sin_o) + longint'(cos_o) * longint'(cos_o);
        if (ss < lim_lo || ss > lim_hi) norm_bad++;
        n_out++;
      end
    end
    check("s4_count", n_out, 1024);
    check("s4_norm", norm_bad, 0);

    // Backpressure
    p5[0] = 100; p5[1] = 300; p5[2] = 600; p5[3] = 900; p5[4] = 1023;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 5);
      phase     = (sent < 5) ? 26'(p5[sent] << 16) : '0;
      #1;
      if (cyc < 3) check("s5_ready_fill", in_ready, 1);
      else if (cyc < 6) check("s5_ready_full", in_ready, 0);
      acc   = (in_valid && in_ready) ? 1 : 0;
      xfer  = (out_valid && out_ready) ? 1 : 0;
      cap_s = sin_o;
      cap_c = cos_o;
      tick();
      if (acc != 0) sent++;
      if (xfer != 0) begin
        check("s5_sin", cap_s, model(p5[got], 1'b0));
        check("s5_cos", cap_c, model(p5[got], 1'b1));
        got++;
      end
    end
    check("s5_sent", sent, 5);
    check("s5_got", got, 5);
    check("s5_drained", out_valid, 0);

    // Reset with samples in flight
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      phase    = 26'((i * 256) << 16);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("s6_pre_valid", out_valid, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_sin", sin_o, 0);
    check("s6_rst_cos", cos_o, 0);
    tick();
    check("s6_flush1", out_valid, 0);
    tick();
    check("s6_flush2", out_valid, 0);
    single("s6_next", 26'h0000000, 101, 32767);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
